regfile_fwd_sb: RTL and testbench

Parametrised next-generation integer register file for the 5-stage RV32I pipeline, read in ID.
- Adds an in-file EX/MEM/WB bypass network with fixed priority.
- Adds a per-register pending scoreboard that raises a stall for long-latency or load-use hazards.
- Adds a post-reset clear sequencer that zeroes the array before the pipeline is released.

---
 rtl/regfile_fwd_sb.sv | 180 ++++++++++++++++++
 tb/tb_regfile_fwd_sb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_fwd_sb.sv
// regfile_fwd_sb: RV32I integer register file, read in ID.
//  - Two combinational read ports. Each port has an EX/MEM/WB bypass
//    network with fixed priority: x0, EX load, EX result, MEM result,
//    WB write-through, pending, and finally the array.
//  - A per-register pending scoreboard. iss_valid sets a pending bit and
//    a WB write clears it. A pending read with no bypass available stalls.
//  - A post-reset clear sequencer zeroes one entry per cycle. ready rises
//    once every entry has been cleared.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   rs1, rs2                       read addresses
//   we, wa, wd                     WB write port
//   ex_fwd, ex_load, ex_rd, ex_data  EX bypass source / load-use marker
//   mem_fwd, mem_rd, mem_data      MEM bypass source
//   iss_valid, iss_rd              long-latency issue (marks pending)
//   rd1, rd2                       read data
//   stall                          ID must hold
//   ready                          clear sequence complete

// Per-port bypass / hazard resolution. Outputs are raw. The top level
// masks them while the file is not in RUN.
module regfile_rd_port #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   a,
  input  logic            ex_load,
  input  logic            ex_fwd,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_fwd,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            pend,
  input  logic [XLEN-1:0] arr,
  output logic [XLEN-1:0] data,
  output logic            hold
);
  // Because a != 0 past the first branch, a source with rd == 0 can
  // never match any later branch.
  always_comb begin
    data = '0;
    hold = 1'b0;
    if (a == '0) begin
      data = '0;
    end else if (ex_load && ex_rd == a) begin
      hold = 1'b1;
    end else if (ex_fwd && ex_rd == a) begin
      data = ex_data;
    end else if (mem_fwd && mem_rd == a) begin
      data = mem_data;
    end else if (we && wa == a) begin
      data = wd;
    end else if (pend) begin
      hold = 1'b1;
    end else begin
      data = arr;
    end
  end
endmodule

module regfile_fwd_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            ex_fwd,
  input  logic            ex_load,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_fwd,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            stall,
  output logic            ready
);
  localparam int NPORTS = 2;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                      state, state_n;
  logic [AW-1:0]               clr_cnt, clr_cnt_n;
  logic [NREGS-1:0][XLEN-1:0]  regfile;
  logic [NREGS-1:0]            pending, pending_n;
  logic                        run;

  // Gating with rst_n drives the outputs to their reset values in the
  // same cycle that reset is asserted, not one edge later.
  assign run = (state == RUN) && rst_n;

  // Clear sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
    end
  end

  // The counter holds at NREGS-1 rather than wrapping.
  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    if (state == CLEAR) begin
      if (clr_cnt == AW'(NREGS - 1)) state_n   = RUN;
      else                           clr_cnt_n = clr_cnt + 1'b1;
    end
  end

  // Array. The array is not reset. The CLEAR pass initialises it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR)            regfile[clr_cnt] <= '0;
      else if (we && wa != '0)       regfile[wa]      <= wd;
    end
  end

  // Scoreboard. The set is applied after the clear, so an issue in the
  // same cycle as a retiring write keeps the bit pending. The newer
  // producer is still in flight.
  always_comb begin
    pending_n = pending;
    if (we && wa != '0)            pending_n[wa]     = 1'b0;
    if (iss_valid && iss_rd != '0) pending_n[iss_rd] = 1'b1;
    pending_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)            pending <= '0;
    else if (state == RUN) pending <= pending_n;
  end

  // Read ports
  logic [NPORTS-1:0][AW-1:0]   rs;
  logic [NPORTS-1:0][XLEN-1:0] rd_p;
  logic [NPORTS-1:0]           hold_p;

  assign rs = {rs2, rs1};

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    regfile_rd_port #(.XLEN(XLEN), .AW(AW)) u_port (
      .a        (rs[p]),
      .ex_load  (ex_load),
      .ex_fwd   (ex_fwd),
      .ex_rd    (ex_rd),
      .ex_data  (ex_data),
      .mem_fwd  (mem_fwd),
      .mem_rd   (mem_rd),
      .mem_data (mem_data),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .pend     (pending[rs[p]]),
      .arr      (regfile[rs[p]]),
      .data     (rd_p[p]),
      .hold     (hold_p[p])
    );
  end

  assign rd1   = run ? rd_p[0] : '0;
  assign rd2   = run ? rd_p[1] : '0;
  assign stall = !run || (|hold_p);
  assign ready = run;
endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Testbench for regfile_fwd_sb.
// A compare process checks every output on every negedge. It compares
// against a model made of an array, a pending array and a clear countdown.
// Directed scenarios also check literal values.
module tb_regfile_fwd_sb;
  localparam int XLEN = 32, NREGS = 32, AW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   rs1, rs2, wa, ex_rd, mem_rd, iss_rd;
  logic            we, ex_fwd, ex_load, mem_fwd, iss_valid;
  logic [XLEN-1:0] wd, ex_data, mem_data, rd1, rd2;
  logic            stall, ready;

  always #5 clk = ~clk;

  regfile_fwd_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .we(we), .wa(wa), .wd(wd),
    .ex_fwd(ex_fwd), .ex_load(ex_load), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_fwd(mem_fwd), .mem_rd(mem_rd), .mem_data(mem_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rd1(rd1), .rd2(rd2), .stall(stall), .ready(ready)
  );

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model
  logic [XLEN-1:0] m_rf [NREGS];
  bit              m_pend [NREGS];
  int              m_left = NREGS;   // cycles of clearing still to go

  // The model counts down the clear cycles. The array contents only
  // matter once ready is high, so the model zeroes all entries at the end.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_left <= NREGS;
      for (int i = 0; i < NREGS; i++) m_pend[i] <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) for (int i = 0; i < NREGS; i++) m_rf[i] <= '0;
    end else begin
      if (we && wa != 0) begin
        m_rf[wa]   <= wd;
        m_pend[wa] <= 1'b0;
      end
      if (iss_valid && iss_rd != 0) m_pend[iss_rd] <= 1'b1;
    end
  end

  function automatic void m_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d,
                                 output bit s);
    d = '0; s = 1'b0;
    if (a == 0)                         d = '0;
    else if (ex_load && ex_rd == a)     s = 1'b1;
    else if (ex_fwd && ex_rd == a)      d = ex_data;
    else if (mem_fwd && mem_rd == a)    d = mem_data;
    else if (we && wa == a)             d = wd;
    else if (m_pend[a])                 s = 1'b1;
    else                                d = m_rf[a];
  endfunction

  logic [XLEN-1:0] e_d1, e_d2;
  bit              e_s1, e_s2;

  always @(negedge clk) begin
    if (chk_en) begin
      if (!(rst_n && m_left == 0)) begin
        chk("m_ready", {31'b0, ready}, 32'd0);
        chk("m_stall", {31'b0, stall}, 32'd1);
        chk("m_rd1",   rd1, 32'd0);
        chk("m_rd2",   rd2, 32'd0);
      end else begin
        m_read(rs1, e_d1, e_s1);
        m_read(rs2, e_d2, e_s2);
        chk("m_ready", {31'b0, ready}, 32'd1);
        chk("m_stall", {31'b0, stall}, {31'b0, e_s1 | e_s2});
        if (!e_s1) chk("m_rd1", rd1, e_d1);
        if (!e_s2) chk("m_rd2", rd2, e_d2);
      end
    end
  end

  // Directed stimulus
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    we = 0; wa = 0; wd = 0; ex_fwd = 0; ex_load = 0; ex_rd = 0; ex_data = 0;
    mem_fwd = 0; mem_rd = 0; mem_data = 0; iss_valid = 0; iss_rd = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      n++;
    end
    chk(nm, n, 32'd32);
    nxt();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 0;
    nxt(); chk_en = 1'b1;
    nxt(); nxt();
    rst_n = 1;
    wait_ready("clear_len");

    // The whole array reads zero after the clear pass.
    for (int a = 0; a < NREGS; a++) begin
      rs1 = AW'(a); rs2 = AW'(NREGS - 1 - a);
      @(negedge clk);
      chk("clr_rd1", rd1, 32'd0);
      chk("clr_rd2", rd2, 32'd0);
      nxt();
    end

    // Write-through, then read from the array.
    we = 1; wa = 5; wd = 32'hDEADBEEF; rs1 = 5;
    @(negedge clk); chk("wt_rd1", rd1, 32'hDEADBEEF); chk("wt_stall", {31'b0, stall}, 0);
    nxt(); idle(); rs1 = 5;
    @(negedge clk); chk("arr_rd1", rd1, 32'hDEADBEEF);
    nxt();

    // Forward priority
    ex_fwd = 1; ex_rd = 7; ex_data = 32'h11;
    mem_fwd = 1; mem_rd = 7; mem_data = 32'h22;
    we = 1; wa = 7; wd = 32'h33; rs1 = 7; rs2 = 7;
    @(negedge clk); chk("pri_ex1", rd1, 32'h11); chk("pri_ex2", rd2, 32'h11);
    nxt(); ex_fwd = 0;
    @(negedge clk); chk("pri_mem", rd1, 32'h22);
    nxt(); mem_fwd = 0;
    @(negedge clk); chk("pri_wb", rd2, 32'h33);
    nxt(); idle();

    // Load-use
    ex_load = 1; ex_rd = 3; rs2 = 3;
    @(negedge clk); chk("lu_stall", {31'b0, stall}, 1);
    nxt(); ex_fwd = 1; ex_data = 32'h99;
    @(negedge clk); chk("lu_over_fwd", {31'b0, stall}, 1);
    nxt(); ex_fwd = 0; ex_rd = 0; rs2 = 0;
    @(negedge clk); chk("lu_x0_stall", {31'b0, stall}, 0); chk("lu_x0_rd2", rd2, 0);
    nxt(); idle();

    // A forwarding source with rd = 0 never matches.
    mem_fwd = 1; mem_rd = 0; mem_data = 32'hBAD; rs1 = 0;
    @(negedge clk); chk("mem_x0", rd1, 0);
    nxt(); idle();

    // Scoreboard
    iss_valid = 1; iss_rd = 9;
    nxt(); idle(); rs1 = 9;
    @(negedge clk); chk("sb_stall_a", {31'b0, stall}, 1);
    nxt();
    @(negedge clk); chk("sb_stall_b", {31'b0, stall}, 1);
    nxt(); we = 1; wa = 9; wd = 32'h5A;
    @(negedge clk); chk("sb_wb_stall", {31'b0, stall}, 0); chk("sb_wb_rd1", rd1, 32'h5A);
    nxt(); idle(); rs1 = 9;
    @(negedge clk); chk("sb_clr_stall", {31'b0, stall}, 0); chk("sb_clr_rd1", rd1, 32'h5A);
    nxt(); iss_valid = 1; iss_rd = 9; we = 1; wa = 9; wd = 32'h77;
    @(negedge clk); chk("sb_both_rd1", rd1, 32'h77);
    nxt(); idle(); rs1 = 9;
    @(negedge clk); chk("sb_both_pend", {31'b0, stall}, 1);
    nxt();

    // Writes to x0 are discarded, and x0 can never be marked pending.
    idle(); we = 1; wa = 0; wd = 32'hFFFF; iss_valid = 1; iss_rd = 0;
    nxt(); idle(); rs1 = 0; rs2 = 0;
    @(negedge clk); chk("x0_rd1", rd1, 0); chk("x0_stall", {31'b0, stall}, 0);
    nxt();

    // Mid-operation reset. x9 is still pending going into the reset.
    we = 1; wa = 4; wd = 32'h1234;
    nxt(); idle(); rs1 = 4;
    @(negedge clk); chk("x4_pre", rd1, 32'h1234);
    nxt();
    rst_n = 0;
    @(negedge clk); chk("rst_ready", {31'b0, ready}, 0); chk("rst_stall", {31'b0, stall}, 1);
    nxt(); rst_n = 1;
    wait_ready("reclear_len");
    rs1 = 4; rs2 = 9;
    @(negedge clk);
    chk("x4_post", rd1, 0); chk("x9_post", rd2, 0); chk("pend_post", {31'b0, stall}, 0);
    nxt();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
